step_pulse_ctrl: RTL and testbench
==================================

// Module: step_pulse_ctrl
// PURPOSE
//  Front end for the processor's clock/step input on the DE2 board. Syncs and debounces a raw
//  active-low KEY and emits clean one-Clk-wide StepEn pulses: one per press (single-step mode)
//  or periodic (run mode). StepEn drives the processor clock-enable. Halt (IR == 16'h5000)
//  stops all pulses.
// PARAMETERS
//  SYNC_STAGES   2           synchronizer flops on KeyN (>=2)
//  DEBOUNCE_CYC  1_000_000   consecutive stable samples before KeyClean changes (20 ms @ 50 MHz)
//  RUN_DIV       25_000_000  Clk cycles per StepEn pulse in run mode (2 Hz @ 50 MHz), >=2
// PORTS
//  Clk       in   1  system clock, CLOCK_50; sole clock domain
//  Reset     in   1  synchronous, active-high
//  KeyN      in   1  raw pushbutton, active-low, asynchronous, bouncy
//  RunMode   in   1  level from SW: 1 = free-run, 0 = single-step
//  Halt      in   1  level from processor: halt instruction in IR
//  StepEn    out  1  one-cycle step/enable pulse, registered
//  KeyClean  out  1  debounced key level, 1 = pressed, registered
//  StateOut  out  2  FSM state: 0 IDLE, 1 HELD, 2 RUN, 3 HALTED
// BEHAVIOUR
//  Reset (sampled at posedge Clk): sync flops = 1 (released); debounce counter = 0;
//   KeyClean = 0; run divider = 0; StepEn = 0; state = IDLE. Reset mid-press/mid-run
//   aborts everything; a still-held key must debounce again before it counts.
//  Sync: KeyN passes through SYNC_STAGES flops; S = inverted last stage (1 = pressed).
//  Debounce: counter clears whenever S == KeyClean. Otherwise it increments. When S has
//   differed for DEBOUNCE_CYC consecutive cycles, KeyClean <= S and the counter clears.
//   Any bounce back to the KeyClean value restarts the count. Latency: KeyClean changes
//   exactly SYNC_STAGES+DEBOUNCE_CYC cycles after the first edge that samples the new KeyN.
//  Press event P = KeyClean rising (registered compare, 1 cycle after KeyClean rises).
//  FSM, priority within each state in the listed order:
//   IDLE:   Halt -> HALTED. RunMode -> RUN (divider = 0). P -> StepEn = 1 for one cycle,
//           then HELD.
//   HELD:   Halt -> HALTED. KeyClean == 0 -> IDLE. Otherwise no pulses, however long the
//           key is held. RunMode is ignored until release.
//   RUN:    Halt -> HALTED (no pulse that cycle). !RunMode -> IDLE (divider = 0). Otherwise
//           divider counts 0..RUN_DIV-1 and wraps. StepEn = 1 exactly on the wrap cycle.
//           First pulse comes RUN_DIV cycles after RUN is entered. Key presses are ignored.
//   HALTED: StepEn = 0. Exit to IDLE only when Halt == 0. The key is ignored, but KeyClean
//           keeps tracking.
//  StepEn is never high for two consecutive cycles.
//  Divider width = $clog2(RUN_DIV). Debounce counter width = $clog2(DEBOUNCE_CYC+1).
//   Neither counter saturates past its terminal value.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYC=4, RUN_DIV=5)
//  1 Reset held 3 cycles -> StepEn=0, KeyClean=0, StateOut=0. KeyN=1 for 20 cycles -> no change.
//  2 KeyN falls clean at edge 0 -> KeyClean=1 after edge 6, single StepEn pulse after edge 7,
//    StateOut=1. Held 100 cycles -> no more pulses. Release -> StateOut=0 after KeyClean falls.
//  3 KeyN toggles every 2 cycles for 30 cycles, then stays high -> KeyClean stays 0, zero pulses.
//  4 RunMode=1 for 23 cycles -> StepEn pulses 5 cycles apart (4 pulses), StateOut=2. Key
//    presses during RUN -> no extra pulses. RunMode=0 -> StateOut=0.
//  5 RUN with Halt=1 on a wrap cycle -> no pulse, StateOut=3. Key press while halted -> no
//    pulse. Halt=0 -> StateOut=0, next press pulses.
//  6 Reset asserted 2 cycles into debounce count -> KeyClean stays 0. Key still held after
//    Reset -> full 6-cycle debounce, then exactly one pulse.

Source files
------------

// File: rtl/step_pulse_ctrl.sv
// Step/run clock-enable front end: syncs and debounces the step key and
// emits single-cycle StepEn pulses per press or periodically in run mode.
module step_pulse_ctrl #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int RUN_DIV      = 25_000_000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       KeyN,
   input  logic       RunMode,
   input  logic       Halt,
   output logic       StepEn,
   output logic       KeyClean,
   output logic [1:0] StateOut
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam int DW = $clog2(RUN_DIV);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      RUN    = 2'd2,
      HALTED = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_pressed;
   logic [CW-1:0]          deb_cnt_q, deb_cnt_d;
   logic                   clean_q, clean_d;
   logic                   clean_prev_q;
   logic                   press;
   logic [DW-1:0]          div_q, div_d;
   logic                   step_q, step_d;
   state_t                 state_q, state_d;

   // Sync chain idles at 1 (key released)
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], KeyN};
      end
   end

   assign s_pressed = ~sync_q[SYNC_STAGES-1];

   always_comb begin
      deb_cnt_d = deb_cnt_q;
      clean_d   = clean_q;
      if (s_pressed == clean_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == CW'(DEBOUNCE_CYC)) begin
         clean_d   = s_pressed;
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + CW'(1);
      end
   end

   assign press = clean_q & ~clean_prev_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      step_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Halt) begin
               state_d = HALTED;
            end else if (RunMode) begin
               state_d = RUN;
               div_d   = '0;
            end else if (press) begin
               step_d  = 1'b1;
               state_d = HELD;
            end
         end
         HELD: begin
            if (Halt) begin
               state_d = HALTED;
            end else if (!clean_q) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (Halt) begin
               state_d = HALTED;
            end else if (!RunMode) begin
               state_d = IDLE;
               div_d   = '0;
            end else if (div_q == DW'(RUN_DIV - 1)) begin
               div_d  = '0;
               step_d = 1'b1;
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         HALTED: begin
            if (!Halt) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         deb_cnt_q    <= '0;
         clean_q      <= 1'b0;
         clean_prev_q <= 1'b0;
         div_q        <= '0;
         step_q       <= 1'b0;
         state_q      <= IDLE;
      end else begin
         deb_cnt_q    <= deb_cnt_d;
         clean_q      <= clean_d;
         clean_prev_q <= clean_q;
         div_q        <= div_d;
         step_q       <= step_d;
         state_q      <= state_d;
      end
   end

   assign StepEn   = step_q;
   assign KeyClean = clean_q;
   assign StateOut = state_q;

endmodule

// File: tb/tb_step_pulse_ctrl.sv
// Scoreboard bench for step_pulse_ctrl: stimulus queues expected pulse
// cycles and level snapshots; a monitor compares them on each negedge.
module tb_step_pulse_ctrl;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       KeyN;
   logic       RunMode;
   logic       Halt;
   logic       StepEn;
   logic       KeyClean;
   logic [1:0] StateOut;

   step_pulse_ctrl #(
      .SYNC_STAGES (2),
      .DEBOUNCE_CYC(4),
      .RUN_DIV     (5)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .KeyN    (KeyN),
      .RunMode (RunMode),
      .Halt    (Halt),
      .StepEn  (StepEn),
      .KeyClean(KeyClean),
      .StateOut(StateOut)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int         at;
      logic       kc;
      logic [1:0] st;
      logic       se;
      string      nm;
   } lvl_t;

   int   cyc = 0;
   int   pq[$];
   lvl_t lq[$];
   bit   done = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic prev_se = 1'b0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic exp_pulse(input int dt);
      pq.push_back(cyc + dt);
   endtask

   task automatic exp_lvl(input int dt, input logic kc,
                          input logic [1:0] st, input logic se,
                          input string nm);
      lvl_t e;
      int   idx;
      e.at = cyc + dt;
      e.kc = kc;
      e.st = st;
      e.se = se;
      e.nm = nm;
      idx  = lq.size();
      while (idx > 0 && lq[idx-1].at > e.at) idx--;
      lq.insert(idx, e);
   endtask

   // Monitor / scoreboard
   always @(negedge Clk) begin
      if (pq.size() > 0 && pq[0] < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_pulse: none at cycle %0d, required pulse", pq[0]);
         void'(pq.pop_front());
      end
      if (StepEn === 1'b1) begin
         checks++;
         if (pq.size() == 0) begin
            errors++;
            $display("FAIL extra_pulse: pulse at cycle %0d, required none", cyc);
         end else begin
            int p;
            p = pq.pop_front();
            if (p != cyc) begin
               errors++;
               $display("FAIL pulse_time: pulse at cycle %0d, required %0d", cyc, p);
            end
         end
         checks++;
         if (prev_se === 1'b1) begin
            errors++;
            $display("FAIL double_pulse: StepEn high at %0d and %0d", cyc - 1, cyc);
         end
      end
      prev_se = StepEn;
      while (lq.size() > 0 && lq[0].at <= cyc) begin
         lvl_t e;
         e = lq.pop_front();
         checks++;
         if (KeyClean !== e.kc || StateOut !== e.st || StepEn !== e.se) begin
            errors++;
            $display("FAIL %s @%0d: kc=%b st=%0d se=%b, required kc=%b st=%0d se=%b",
                     e.nm, cyc, KeyClean, StateOut, StepEn, e.kc, e.st, e.se);
         end
      end
      if (done || cyc > 3000) begin
         checks++;
         if (cyc > 3000) begin
            errors++;
            $display("FAIL timeout: cycle %0d, required done", cyc);
         end
         checks++;
         if (pq.size() != 0 || lq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d pulses %0d levels pending, required 0",
                     pq.size(), lq.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      Reset   = 1'b1;
      KeyN    = 1'b1;
      RunMode = 1'b0;
      Halt    = 1'b0;

      // 1: reset and quiet key
      @(negedge Clk);
      exp_lvl(2, 1'b0, 2'd0, 1'b0, "reset");
      tick(2);
      Reset = 1'b0;
      for (int i = 1; i <= 20; i++) exp_lvl(i, 1'b0, 2'd0, 1'b0, "idle_quiet");
      tick(20);

      // 2: clean press, long hold, release
      KeyN = 1'b0;
      exp_pulse(8);
      exp_lvl(6, 1'b0, 2'd0, 1'b0, "deb_early");
      exp_lvl(7, 1'b1, 2'd0, 1'b0, "deb_done");
      exp_lvl(8, 1'b1, 2'd1, 1'b1, "press_pulse");
      exp_lvl(9, 1'b1, 2'd1, 1'b0, "pulse_width");
      exp_lvl(99, 1'b1, 2'd1, 1'b0, "held_long");
      tick(100);
      KeyN = 1'b1;
      exp_lvl(6, 1'b1, 2'd1, 1'b0, "rel_early");
      exp_lvl(7, 1'b0, 2'd1, 1'b0, "rel_kc");
      exp_lvl(8, 1'b0, 2'd0, 1'b0, "rel_idle");
      tick(12);

      // 3: bouncing key
      for (int i = 1; i <= 42; i++) exp_lvl(i, 1'b0, 2'd0, 1'b0, "bounce");
      for (int i = 0; i < 15; i++) begin
         KeyN = ~KeyN;
         tick(2);
      end
      KeyN = 1'b1;
      tick(12);

      // 4: run mode with a key press mid-run
      RunMode = 1'b1;
      exp_pulse(6);
      exp_pulse(11);
      exp_pulse(16);
      exp_pulse(21);
      exp_lvl(1, 1'b0, 2'd2, 1'b0, "run_enter");
      exp_lvl(6, 1'b0, 2'd2, 1'b1, "run_pulse");
      exp_lvl(10, 1'b1, 2'd2, 1'b0, "run_key");
      exp_lvl(21, 1'b0, 2'd2, 1'b1, "run_pulse4");
      tick(2);
      KeyN = 1'b0;
      tick(10);
      KeyN = 1'b1;
      tick(11);
      RunMode = 1'b0;
      exp_lvl(1, 1'b0, 2'd0, 1'b0, "run_exit");
      tick(5);

      // 5: halt on wrap, key while halted, resume
      RunMode = 1'b1;
      exp_pulse(6);
      tick(10);
      Halt = 1'b1;
      exp_lvl(1, 1'b0, 2'd3, 1'b0, "halt_wrap");
      tick(1);
      RunMode = 1'b0;
      KeyN = 1'b0;
      exp_lvl(8, 1'b1, 2'd3, 1'b0, "halt_key");
      tick(12);
      KeyN = 1'b1;
      tick(10);
      Halt = 1'b0;
      exp_lvl(1, 1'b0, 2'd0, 1'b0, "unhalt");
      tick(2);
      KeyN = 1'b0;
      exp_pulse(8);
      exp_lvl(8, 1'b1, 2'd1, 1'b1, "post_halt_press");
      tick(20);
      KeyN = 1'b1;
      tick(10);

      // 6: reset mid-debounce with key still held
      KeyN = 1'b0;
      tick(4);
      Reset = 1'b1;
      exp_lvl(1, 1'b0, 2'd0, 1'b0, "rst_mid");
      tick(2);
      Reset = 1'b0;
      exp_pulse(8);
      exp_lvl(3, 1'b0, 2'd0, 1'b0, "rst_no_carry");
      exp_lvl(6, 1'b0, 2'd0, 1'b0, "rst_redeb_early");
      exp_lvl(7, 1'b1, 2'd0, 1'b0, "rst_redeb");
      exp_lvl(8, 1'b1, 2'd1, 1'b1, "rst_pulse");
      tick(20);
      KeyN = 1'b1;
      tick(12);

      done = 1'b1;
   end

endmodule
